// File: rtl/gmii_rx_frame_parser.sv
// GMII receive byte stage: strips preamble/SFD, checks the CRC-32 FCS, length-checks the frame,
// streams payload without FCS and reports one status word per frame. Define GMII_RX_STATS_EN for frame counters.
module gmii_rx_frame_parser #(
   parameter int min_len_p    = 60,
   parameter int max_len_p    = 1514,
   parameter int stat_width_p = 32
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    en_i,
   input  logic [7:0]              gmii_rxd_i,
   input  logic                    gmii_rx_dv_i,
   input  logic                    gmii_rx_er_i,
   output logic [7:0]              data_o,
   output logic                    valid_o,
   output logic                    status_v_o,
   output logic [10:0]             len_o,
   output logic                    crc_err_o,
   output logic                    rx_err_o,
   output logic                    runt_o,
   output logic                    giant_o,
   output logic [stat_width_p-1:0] good_cnt_o,
   output logic [stat_width_p-1:0] crc_cnt_o
);

   localparam logic [1:0] st_idle     = 2'd0;
   localparam logic [1:0] st_preamble = 2'd1;
   localparam logic [1:0] st_payload  = 2'd2;
   localparam logic [1:0] st_drop     = 2'd3;

   localparam logic [7:0]  preamble_byte = 8'h55;
   localparam logic [7:0]  sfd_byte      = 8'hD5;
   localparam logic [31:0] crc_residue   = 32'hDEBB20E3;

   // Limits expressed on the raw byte count, which includes the 4 FCS bytes.
   localparam logic [11:0] runt_lim  = 12'(min_len_p + 4);
   localparam logic [11:0] giant_lim = 12'(max_len_p + 4);

   logic [1:0]  state, state_n;
   logic [31:0] crc;
   logic [31:0] crc_next;
   logic [11:0] count;
   logic [11:0] count_inc;
   logic [11:0] len_full;
   logic [10:0] len_calc;
   logic [7:0]  dl [4];
   logic        rx_err;
   logic        start_frame;
   logic        payload_byte;
   logic        frame_end;
   logic        crc_bad;
   logic        good_frame;

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'h0, d};
      for (int b = 0; b < 8; b++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   always_comb begin
      state_n     = state;
      start_frame = 1'b0;
      if (en_i) begin
         case (state)
            st_idle: begin
               if (gmii_rx_dv_i) begin
                  if (gmii_rxd_i == preamble_byte) state_n = st_preamble;
                  else if (gmii_rxd_i == sfd_byte) begin
                     state_n     = st_payload;
                     start_frame = 1'b1;
                  end else state_n = st_drop;
               end
            end
            st_preamble: begin
               if (!gmii_rx_dv_i) state_n = st_idle;
               else if (gmii_rxd_i == sfd_byte) begin
                  state_n     = st_payload;
                  start_frame = 1'b1;
               end else if (gmii_rxd_i != preamble_byte) state_n = st_drop;
            end
            st_payload: if (!gmii_rx_dv_i) state_n = st_idle;
            default:    if (!gmii_rx_dv_i) state_n = st_idle;
         endcase
      end
   end

   always_comb begin
      payload_byte = en_i && (state == st_payload) && gmii_rx_dv_i;
      frame_end    = en_i && (state == st_payload) && !gmii_rx_dv_i;
      crc_next     = crc_byte(crc, gmii_rxd_i);
      count_inc    = (count == 12'hFFF) ? count : count + 12'd1;
      len_full     = count - 12'd4;
      if (count < 12'd4)          len_calc = 11'd0;
      else if (len_full > 12'd2047) len_calc = 11'h7FF;
      else                        len_calc = len_full[10:0];
      crc_bad    = (crc != crc_residue);
      good_frame = !crc_bad && !rx_err && (count >= runt_lim) && (count <= giant_lim);
   end

   // NOTE: the FCS delay line is reset along with the control state so a frame never sees stale bytes.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state      <= st_idle;
         crc        <= 32'hFFFFFFFF;
         count      <= '0;
         rx_err     <= 1'b0;
         for (int i = 0; i < 4; i++) dl[i] <= '0;
         data_o     <= '0;
         valid_o    <= 1'b0;
         status_v_o <= 1'b0;
         len_o      <= '0;
         crc_err_o  <= 1'b0;
         rx_err_o   <= 1'b0;
         runt_o     <= 1'b0;
         giant_o    <= 1'b0;
      end else begin
         valid_o    <= 1'b0;
         status_v_o <= 1'b0;
         state      <= state_n;
         if (start_frame) begin
            crc    <= 32'hFFFFFFFF;
            count  <= '0;
            rx_err <= 1'b0;
            for (int i = 0; i < 4; i++) dl[i] <= '0;
         end
         if (payload_byte) begin
            crc   <= crc_next;
            count <= count_inc;
            dl[0] <= gmii_rxd_i;
            for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
            if (gmii_rx_er_i) rx_err <= 1'b1;
            // The oldest byte leaves the line once 4 newer bytes follow it, up to max_len_p bytes.
            if (count_inc >= 12'd5 && count_inc <= giant_lim) begin
               valid_o <= 1'b1;
               data_o  <= dl[3];
            end
         end
         if (frame_end) begin
            status_v_o <= 1'b1;
            len_o      <= len_calc;
            crc_err_o  <= crc_bad;
            rx_err_o   <= rx_err;
            runt_o     <= (count < runt_lim);
            giant_o    <= (count > giant_lim);
         end
      end
   end

`ifdef GMII_RX_STATS_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         good_cnt_o <= '0;
         crc_cnt_o  <= '0;
      end else if (frame_end) begin
         if (good_frame) good_cnt_o <= good_cnt_o + stat_width_p'(1);
         if (crc_bad)    crc_cnt_o  <= crc_cnt_o + stat_width_p'(1);
      end
   end
`else
   assign good_cnt_o = '0;
   assign crc_cnt_o  = '0;
   logic unused_stats;
   assign unused_stats = good_frame;
`endif

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Self-checking bench for gmii_rx_frame_parser: table-driven frames, randomized frames against a
// frame-level reference model, and hand sequences for drop, reset abort and ignored rx_er.
module tb_gmii_rx_frame_parser;
   localparam int min_len = 60;
   localparam int max_len = 1514;
   localparam int sw      = 32;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          en_i = 1'b0;
   logic [7:0]    rxd = 8'h00;
   logic          dv = 1'b0;
   logic          er = 1'b0;
   logic [7:0]    data_o;
   logic          valid_o, status_v_o, crc_err_o, rx_err_o, runt_o, giant_o;
   logic [10:0]   len_o;
   logic [sw-1:0] good_cnt_o, crc_cnt_o;

   gmii_rx_frame_parser #(.min_len_p(min_len), .max_len_p(max_len), .stat_width_p(sw)) dut (
      .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .gmii_rxd_i(rxd), .gmii_rx_dv_i(dv),
      .gmii_rx_er_i(er), .data_o(data_o), .valid_o(valid_o), .status_v_o(status_v_o),
      .len_o(len_o), .crc_err_o(crc_err_o), .rx_err_o(rx_err_o), .runt_o(runt_o),
      .giant_o(giant_o), .good_cnt_o(good_cnt_o), .crc_cnt_o(crc_cnt_o));

   always #5 clk = ~clk;

   typedef struct {
      int pre; int dlen; bit fcs; int corrupt; int er; int div;
      int e_len; bit e_crc; bit e_rx; bit e_runt; bit e_giant; int e_nvalid;
   } vec_t;

   typedef struct { logic [10:0] len; logic crc; logic rx; logic runt; logic giant; } stat_t;

   int         checks = 0, errors = 0, overlap = 0;
   longint     exp_good = 0, exp_crc = 0;
   logic [7:0] frm[$];
   logic [7:0] got_q[$];
   stat_t      stat_q[$];

   always @(negedge clk) begin
      if (valid_o) got_q.push_back(data_o);
      if (status_v_o) stat_q.push_back('{len_o, crc_err_o, rx_err_o, runt_o, giant_o});
      if (valid_o && status_v_o) overlap++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   // Standard Ethernet FCS (inverted CRC-32) over the first n frame bytes.
   function automatic logic [31:0] fcs_of(input int n);
      logic [31:0] c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c ^= {24'h0, frm[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build(input int dlen, input bit rnd, input bit add_fcs);
      logic [31:0] f;
      frm.delete();
      for (int i = 0; i < dlen; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i));
      if (add_fcs) begin
         f = fcs_of(dlen);
         for (int k = 0; k < 4; k++) frm.push_back(f[8*k +: 8]);
      end
   endtask

   task automatic drive_byte(input logic v, input logic [7:0] b, input logic e, input int div);
      @(posedge clk); #1;
      dv = v; rxd = b; er = e; en_i = 1'b1;
      for (int k = 1; k < div; k++) begin
         @(posedge clk); #1;
         en_i = 1'b0;
      end
   endtask

   task automatic send(input int pre, input int er_idx, input int div, input bit er_idle);
      for (int p = 0; p < pre; p++) drive_byte(1'b1, 8'h55, 1'b0, div);
      drive_byte(1'b1, 8'hD5, 1'b0, div);
      for (int i = 0; i < frm.size(); i++) drive_byte(1'b1, frm[i], (i == er_idx), div);
      for (int g = 0; g < 3; g++) drive_byte(1'b0, 8'h00, er_idle, div);
      @(posedge clk); #1;
      er = 1'b0;
   endtask

   task automatic check_stats(input string tag);
      longint eg = exp_good, ec = exp_crc;
`ifndef GMII_RX_STATS_EN
      eg = 0; ec = 0;
`endif
      check({tag, "_good_cnt"}, good_cnt_o, eg);
      check({tag, "_crc_cnt"}, crc_cnt_o, ec);
   endtask

   task automatic run(input vec_t vin, input bit rnd, input string tag);
      vec_t v = vin;
      int   n, mism;
      build(v.dlen, rnd, v.fcs);
      n = frm.size();
      if (v.corrupt >= 0 && v.corrupt < n)
         frm[v.corrupt] = frm[v.corrupt] ^ (8'h01 << (rnd ? $urandom_range(0, 7) : 0));
      if (rnd) begin
         v.e_len    = (n < 4) ? 0 : ((n - 4 > 2047) ? 2047 : n - 4);
         v.e_crc    = (n < 4) ? 1'b1 :
                      ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} != fcs_of(n - 4));
         v.e_rx     = (v.er >= 0 && v.er < n);
         v.e_runt   = (n < min_len + 4);
         v.e_giant  = (n > max_len + 4);
         v.e_nvalid = (n <= 4) ? 0 : ((n - 4 > max_len) ? max_len : n - 4);
      end
      got_q.delete();
      stat_q.delete();
      send(v.pre, v.er, v.div, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (!v.e_crc && !v.e_rx && !v.e_runt && !v.e_giant) exp_good++;
      if (v.e_crc) exp_crc++;
      check({tag, "_nstat"}, stat_q.size(), 1);
      if (stat_q.size() > 0) begin
         check({tag, "_len"}, stat_q[0].len, v.e_len);
         check({tag, "_crc_err"}, stat_q[0].crc, v.e_crc);
         check({tag, "_rx_err"}, stat_q[0].rx, v.e_rx);
         check({tag, "_runt"}, stat_q[0].runt, v.e_runt);
         check({tag, "_giant"}, stat_q[0].giant, v.e_giant);
      end
      check({tag, "_nvalid"}, got_q.size(), v.e_nvalid);
      mism = 0;
      for (int i = 0; i < got_q.size(); i++)
         if (i >= n || got_q[i] != frm[i]) mism++;
      check({tag, "_data_mism"}, mism, 0);
      check_stats(tag);
   endtask

   vec_t vt[13];

   initial begin
      //          pre dlen fcs corrupt er div  len crc rx runt giant nvalid
      vt[0]  = '{7, 64,   1, -1, -1, 1,   64,  0, 0, 0, 0, 64};
      vt[1]  = '{7, 64,   1, 16, -1, 1,   64,  1, 0, 0, 0, 64};
      vt[2]  = '{1, 20,   1, -1, -1, 1,   20,  0, 0, 1, 0, 20};
      vt[3]  = '{7, 1600, 1, -1, -1, 1,   1600, 0, 0, 0, 1, 1514};
      vt[4]  = '{7, 64,   1, -1, 30, 10,  64,  0, 1, 0, 0, 64};
      vt[5]  = '{0, 0,    1, -1, -1, 1,   0,   0, 0, 1, 0, 0};
      vt[6]  = '{1, 3,    0, -1, -1, 1,   0,   1, 0, 1, 0, 0};
      vt[7]  = '{2, 1,    1, -1, -1, 2,   1,   0, 0, 1, 0, 1};
      vt[8]  = '{7, 60,   1, -1, -1, 1,   60,  0, 0, 0, 0, 60};
      vt[9]  = '{7, 59,   1, -1, -1, 1,   59,  0, 0, 1, 0, 59};
      vt[10] = '{7, 1514, 1, -1, -1, 1,   1514, 0, 0, 0, 0, 1514};
      vt[11] = '{7, 1515, 1, -1, -1, 1,   1515, 0, 0, 0, 1, 1514};
      vt[12] = '{7, 2100, 1, -1, -1, 1,   2047, 0, 0, 0, 1, 1514};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", valid_o, 0);
      check("rst_status", status_v_o, 0);
      check("rst_len", len_o, 0);
      check("rst_flags", {crc_err_o, rx_err_o, runt_o, giant_o}, 0);
      check("rst_data", data_o, 0);
      check_stats("rst");
      @(posedge clk); #1;
      reset_i = 1'b0;

      for (int i = 0; i < 13; i++) run(vt[i], 1'b0, $sformatf("vec%0d", i));

      // Frame starting with a non-preamble byte, then one with a corrupt preamble: both dropped.
      got_q.delete(); stat_q.delete();
      drive_byte(1'b1, 8'h12, 1'b0, 1);
      for (int i = 0; i < 30; i++) drive_byte(1'b1, 8'(i), 1'b0, 1);
      for (int g = 0; g < 3; g++) drive_byte(1'b0, 8'h00, 1'b0, 1);
      drive_byte(1'b1, 8'h55, 1'b0, 1);
      drive_byte(1'b1, 8'h55, 1'b0, 1);
      drive_byte(1'b1, 8'h33, 1'b0, 1);
      drive_byte(1'b1, 8'hD5, 1'b0, 1);
      for (int i = 0; i < 20; i++) drive_byte(1'b1, 8'(i), 1'b0, 1);
      for (int g = 0; g < 3; g++) drive_byte(1'b0, 8'h00, 1'b0, 1);
      check("drop_nstat", stat_q.size(), 0);
      check("drop_nvalid", got_q.size(), 0);

      // Reset asserted at byte 40 and released while dv is still high.
      build(64, 1'b0, 1'b1);
      got_q.delete(); stat_q.delete();
      for (int p = 0; p < 7; p++) drive_byte(1'b1, 8'h55, 1'b0, 1);
      drive_byte(1'b1, 8'hD5, 1'b0, 1);
      for (int i = 0; i < 40; i++) drive_byte(1'b1, frm[i], 1'b0, 1);
      @(posedge clk); #1;
      reset_i = 1'b1; rxd = frm[40];
      @(negedge clk);
      check("abort_valid", valid_o, 0);
      check("abort_status", status_v_o, 0);
      check("abort_len", len_o, 0);
      exp_good = 0; exp_crc = 0;
      check_stats("abort");
      @(posedge clk); #1;
      rxd = frm[41];
      @(posedge clk); #1;
      reset_i = 1'b0; rxd = frm[42];
      for (int i = 43; i < frm.size(); i++) drive_byte(1'b1, frm[i], 1'b0, 1);
      for (int g = 0; g < 3; g++) drive_byte(1'b0, 8'h00, 1'b0, 1);
      check("abort_nstat", stat_q.size(), 0);
      check("abort_nvalid_le36", (got_q.size() <= 36), 1);
      run(vt[0], 1'b0, "post_abort");

      for (int r = 0; r < 10; r++) begin
         vec_t v;
         int   n;
         v = vt[0];
         v.pre  = $urandom_range(0, 7);
         v.dlen = ($urandom_range(0, 7) == 0) ? $urandom_range(1400, 1600) : $urandom_range(0, 150);
         v.div  = $urandom_range(1, 3);
         n      = v.dlen + 4;
         v.corrupt = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
         v.er      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         run(v, 1'b1, $sformatf("rnd%0d", r));
      end

      check("pulse_overlap", overlap, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
